// File: rtl/ravan_encryption.sv
// Iterative RAVAN encryption engine: one 64-bit block per handshake,
// one full 8-step round per clock, ROUNDS rounds, result held until taken.
module ravan_encryption #(
  parameter int ROUNDS = 21
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [63:0]  data_in,
  input  logic [63:0]  tweak,
  input  logic [511:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  enc_data_out,
  output logic         busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [7:0] LAST_ROUND = 8'(ROUNDS - 1);

  state_t       r_state;
  state_t       w_next;
  logic [63:0]  r_t;
  logic [63:0]  r_tweak;
  logic [511:0] r_key;
  logic [7:0]   r_round_cnt;
  logic [63:0]  w_round;
  logic         w_accept;

  // Forward step is the inverse of the decryptor's t = ~(t - tweak) ^ k[i],
  // applied over ascending key slices.
  function automatic logic [63:0] enc_round(input logic [63:0]  t_in,
                                            input logic [511:0] k,
                                            input logic [63:0]  tw);
    logic [63:0] t;
    t = t_in;
    for (int i = 0; i < 8; i++) begin
      t = ~(t ^ k[64*i +: 64]) + tw;
    end
    return t;
  endfunction

  assign w_round  = enc_round(r_t, r_key, r_tweak);
  assign w_accept = in_valid && (r_state == S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (in_valid)                    w_next = S_RUN;
      S_RUN:  if (r_round_cnt == LAST_ROUND)   w_next = S_DONE;
      S_DONE: if (out_ready)                   w_next = S_IDLE;
      default:                                 w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_t         <= '0;
      r_key       <= '0;
      r_tweak     <= '0;
      r_round_cnt <= '0;
    end else if (w_accept) begin
      r_t         <= data_in;
      r_key       <= key;
      r_tweak     <= tweak;
      r_round_cnt <= '0;
    end else if (r_state == S_RUN) begin
      r_t         <= w_round;
      r_round_cnt <= r_round_cnt + 8'd1;
    end
  end

  // Handshake outputs decode straight from state so reset clears them at once.
  assign in_ready     = (r_state == S_IDLE);
  assign out_valid    = (r_state == S_DONE);
  assign busy         = ~in_ready;
  assign enc_data_out = r_t;

endmodule

// File: tb/tb_ravan_encryption.sv
// Bench for ravan_encryption: vector table, random blocks with scoreboard,
// handshake hold, input toggling, back-to-back accepts and mid-run reset.
module tb_ravan_encryption;

  localparam int ROUNDS = 21;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  data_in;
  logic [63:0]  tweak;
  logic [511:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  enc_data_out;
  logic         busy;

  int n_chk  = 0;
  int n_pass = 0;
  logic [63:0] exp_q[$];

  typedef struct {
    logic [63:0]  d;
    logic [511:0] k;
    logic [63:0]  tw;
    logic [63:0]  exp;
  } vec_t;

  vec_t vecs[3];

  ravan_encryption #(.ROUNDS(ROUNDS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .tweak(tweak), .key(key), .out_valid(out_valid),
    .out_ready(out_ready), .enc_data_out(enc_data_out), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] enc_model(input logic [63:0] d, input logic [511:0] k,
                                            input logic [63:0] tw);
    logic [63:0] t;
    t = d;
    for (int r = 0; r < ROUNDS; r++)
      for (int i = 0; i < 8; i++) t = ~(t ^ k[64*i +: 64]) + tw;
    return t;
  endfunction

  function automatic logic [63:0] dec_model(input logic [63:0] c, input logic [511:0] k,
                                            input logic [63:0] tw);
    logic [63:0] t;
    t = c;
    for (int r = 0; r < ROUNDS; r++)
      for (int i = 7; i >= 0; i--) t = ~(t - tw) ^ k[64*i +: 64];
    return t;
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, expv);
  endtask

  // Runs one block; called with the bench aligned to a falling edge.
  task automatic run_block(input logic [63:0] d, input logic [511:0] k, input logic [63:0] tw,
                           input bit early_rdy, input bit toggle, input int hold);
    int w;
    int lat;
    logic [63:0] held;
    logic [63:0] expv;
    w = 0;
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("idle_ready", {63'd0, in_ready}, 64'd1);
    data_in  = d;
    key      = k;
    tweak    = tw;
    in_valid = 1'b1;
    exp_q.push_back(enc_model(d, k, tw));
    @(posedge clk);
    lat = 0;
    do begin
      #1;
      in_valid = 1'b0;
      if (early_rdy) out_ready = 1'b1;
      if (toggle) begin
        data_in = rand64();
        key     = rand512();
        tweak   = rand64();
      end
      if (!out_valid) begin
        @(posedge clk);
        lat++;
      end
    end while (!out_valid && lat <= 60);
    chk("latency", 64'(lat), 64'(ROUNDS));
    @(negedge clk);
    chk("done_busy", {62'd0, busy, in_ready}, 64'd2);
    for (int h = 0; h < hold; h++) begin
      held = enc_data_out;
      @(negedge clk);
      chk("hold_stable", enc_data_out, held);
      chk("hold_flags", {62'd0, in_ready, out_valid}, 64'd1);
    end
    expv = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
    chk("ciphertext", enc_data_out, expv);
    chk("inverse", dec_model(enc_data_out, k, tw), d);
    out_ready = 1'b1;
    @(negedge clk);
    chk("release", {62'd0, in_ready, out_valid}, 64'd2);
    out_ready = 1'b0;
  endtask

  initial begin
    int acc_t[$];
    int n_out;
    logic [511:0] k;
    logic [63:0]  d;
    logic [63:0]  tw;
    logic [63:0]  expv;

    vecs[0] = '{d: 64'h0123456789ABCDEF, k: '0, tw: 64'd0, exp: 64'h0123456789ABCDEF};
    vecs[1] = '{d: 64'd0, k: 512'd1, tw: 64'd0, exp: 64'h0000000000000001};
    vecs[2] = '{d: 64'd5, k: '0, tw: 64'd1, exp: 64'd5};

    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    data_in = '0; key = '0; tweak = '0;
    #1;
    chk("rst_flags", {61'd0, in_ready, out_valid, busy}, 64'd4);
    chk("rst_data", enc_data_out, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 3; v++) begin
      exp_q.push_back(vecs[v].exp);
      run_block(vecs[v].d, vecs[v].k, vecs[v].tw, 1'b0, 1'b0, 0);
      // run_block also queued the model value; table constant is checked first.
      void'(exp_q.pop_front());
    end

    run_block(64'hDEADBEEFCAFEF00D, rand512(), rand64(), 1'b0, 1'b0, 10);
    run_block(rand64(), rand512(), rand64(), 1'b0, 1'b1, 0);
    run_block(rand64(), rand512(), rand64(), 1'b1, 1'b0, 0);

    for (int b = 0; b < 1000; b++)
      run_block(rand64(), rand512(), rand64(), bit'($urandom_range(0, 1)),
                ($urandom_range(0, 3) == 0), 0);

    // Back-to-back: in_valid and out_ready held high.
    d = 64'h0F1E2D3C4B5A6978; k = rand512(); tw = rand64();
    expv = enc_model(d, k, tw);
    data_in = d; key = k; tweak = tw;
    in_valid = 1'b1; out_ready = 1'b1; n_out = 0;
    for (int c = 0; c < 70; c++) begin
      if (acc_t.size() == 3 && !in_ready) in_valid = 1'b0;
      if (in_ready && in_valid) begin
        acc_t.push_back(c);
        exp_q.push_back(expv);
      end
      if (out_valid) begin
        n_out++;
        chk("b2b_data", enc_data_out, exp_q.size() > 0 ? exp_q.pop_front() : 64'hx);
      end
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("b2b_count", 64'(n_out), 64'd3);
    chk("b2b_accepts", 64'(acc_t.size()), 64'd3);
    if (acc_t.size() == 3) begin
      chk("b2b_period1", 64'(acc_t[1] - acc_t[0]), 64'(ROUNDS + 2));
      chk("b2b_period2", 64'(acc_t[2] - acc_t[1]), 64'(ROUNDS + 2));
    end
    exp_q.delete();

    // Reset asserted mid-run, between clock edges.
    data_in = rand64(); key = rand512(); tweak = rand64(); in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("pre_rst_busy", {63'd0, busy}, 64'd1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_flags", {61'd0, in_ready, out_valid, busy}, 64'd4);
    chk("mid_rst_data", enc_data_out, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_block(64'h0123456789ABCDEF, rand512(), rand64(), 1'b0, 1'b0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/ravan_encryption.md
# ravan_encryption

Iterative RAVAN 512-bit-key encryption engine, the forward-direction counterpart of the RAVAN decryption block. It accepts one 64-bit plaintext block and a 64-bit tweak through a valid/ready handshake, then runs ROUNDS rounds of 8 key-slice steps, one full round per clock. It returns the ciphertext through a second valid/ready handshake. Each step is the exact inverse of the decryption step, so decrypting the output with the same key and tweak restores the plaintext.

## Interface
- ROUNDS, 21, number of rounds; legal range 1..255.
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-low reset: 0 resets, 1 runs.
- in_valid  input  1  plaintext, key and tweak are valid.
- in_ready  output  1  engine idle and able to accept a block.
- data_in  input  64  plaintext block.
- tweak  input  64  per-block tweak; equals the decryptor's real_data operand.
- key  input  512  encryption key.
- out_valid  output  1  enc_data_out holds a finished ciphertext.
- out_ready  input  1  consumer accepts the ciphertext.
- enc_data_out  output  64  ciphertext.
- busy  output  1  high in RUN and DONE.

## Operation
- Key slices: slice k[i] = key[64*i+63 : 64*i], for i = 0..7.
- Step i, 64-bit modular arithmetic with carry discarded:
  - t = ~(t ^ k[i]) + tweak
- Round: steps i = 0,1,...,7 applied in ascending order, combinationally, within one cycle.
- Datapath registers: t_reg (64), key_reg (512), tweak_reg (64), round_cnt (8).
  - Key and tweak are captured at accept.
  - Changes on data_in, key or tweak after accept have no effect on the block in flight.
- FSM states: IDLE, RUN, DONE.
  - IDLE: in_ready = 1. On in_valid && in_ready, load t_reg <= data_in, key_reg <= key, tweak_reg <= tweak, round_cnt <= 0, and go to RUN.
  - RUN: each cycle, t_reg <= round(t_reg) and round_cnt <= round_cnt + 1. When round_cnt == ROUNDS-1, go to DONE.
  - DONE: out_valid = 1 and enc_data_out = t_reg, held stable. On out_ready, go to IDLE.
- in_valid asserted outside IDLE is ignored; there is no queueing.
- out_ready asserted outside DONE is ignored.
- enc_data_out is driven from t_reg in every state. Consumers sample it only while out_valid = 1.
- Reset values, asynchronous, applied immediately:
  - state = IDLE
  - in_ready = 1, out_valid = 0, busy = 0
  - enc_data_out = 0
  - t_reg, key_reg, tweak_reg, round_cnt = 0
- Reset mid-operation (RUN or DONE) discards the block. After release the engine is in IDLE with no output pending.
- Reset release is synchronous to clk; the first accept can happen on the first rising edge after release.

## Timing
- Accept at edge N, when in_valid && in_ready are both high.
- Rounds 1..ROUNDS are applied at edges N+1 .. N+ROUNDS.
- out_valid rises after edge N+ROUNDS, which is 21 cycles after accept at the default ROUNDS.
- out_ready sampled high at edge M, where M ≥ N+ROUNDS+... (first DONE edge): out_valid falls and in_ready rises after edge M.
- Next accept is possible at edge M+1.
- Minimum block period is ROUNDS+2 cycles (23 at the default).
- out_ready already high on arrival in DONE: a single DONE cycle, out_valid high for exactly 1 cycle.
- in_ready and out_valid are never high in the same cycle.
- busy = ~in_ready.

## Test plan
- Key = 0, tweak = 0, data_in = 0x0123456789ABCDEF:
  - Each step reduces to a plain inversion and an even total inverts back.
  - Required: enc_data_out = 0x0123456789ABCDEF, out_valid rising exactly 21 cycles after accept.
- Key slice 0 = 0x1, slices 1..7 = 0, tweak = 0, data_in = 0:
  - Each round reduces to t ^ 1, and 21 rounds give an odd count.
  - Required: enc_data_out = 0x0000000000000001.
- Key = 0, tweak = 0x1, data_in = 0x5:
  - Each step reduces to negation, and the total count is even.
  - Required: enc_data_out = 0x5.
- Random key, tweak and data over 1000 blocks against a bench model of the step equation:
  - Outputs match the model.
  - Applying the inverse step t = ~(t - tweak) ^ k[i] (i = 7..0, ROUNDS times) restores data_in.
- Handshake and input-change checks:
  - Hold out_ready = 0 for 10 cycles in DONE: enc_data_out is stable and in_ready stays 0.
  - Toggle data_in, key and tweak during RUN: the result is unchanged.
  - in_valid held high continuously: blocks are accepted every 23 cycles.
- Reset checks:
  - Drive rst = 0 at round 10: all outputs take reset values immediately, with no clock edge needed.
  - After release, a fresh block completes correctly with full 21-cycle latency.
